// File: rtl/matrix_xfer_pkg.sv
// Shared types and default geometry for the matrix transfer sequencer.
// N and W are derived from the defaults; the top recomputes them from its own parameters.
package matrix_xfer_pkg;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    localparam int N = DIM * DIM;
    localparam int W = (N * ELEM_W + DATA_W - 1) / DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        FIN
    } state_t;

endpackage

// File: rtl/matrix_xfer.sv
// Load/store sequencer moving a DIM x DIM matrix between a local buffer and memory_mod, one word per handshake.
// Optional: define MATRIX_XFER_OVF_EN to add the addr_ovf output flagging address wrap within a transfer.
module matrix_xfer #(
    parameter int DIM    = matrix_xfer_pkg::DIM,
    parameter int ELEM_W = matrix_xfer_pkg::ELEM_W,
    parameter int DATA_W = matrix_xfer_pkg::DATA_W,
    parameter int ADDR_W = matrix_xfer_pkg::ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [ADDR_W-1:0]            cmd_base,
    input  logic [DIM*DIM*ELEM_W-1:0]    wr_matrix,
    output logic [DIM*DIM*ELEM_W-1:0]    rd_matrix,
    output logic                         busy,
    output logic                         xfer_done,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         mem_start,
    output logic                         mem_wr,
    input  logic                         mem_done
`ifdef MATRIX_XFER_OVF_EN
   ,output logic                         addr_ovf
`endif
);
    import matrix_xfer_pkg::*;

    localparam int          NUM_ELEM  = DIM * DIM;
    localparam int          MAT_W     = NUM_ELEM * ELEM_W;
    localparam int          NUM_WORDS = (MAT_W + DATA_W - 1) / DATA_W;
    localparam int unsigned BPW       = DATA_W / ELEM_W;
    localparam int          K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_WORDS - 1);

    state_t              state, state_next;
    logic [K_W-1:0]      k, k_next;
    logic [ADDR_W-1:0]   base_q, base_next;
    logic                op_q, op_next;
    logic [MAT_W-1:0]    buf_q, buf_next;
    logic [DATA_W-1:0]   word_next;
    int unsigned         ld_idx, wr_idx;

`ifdef MATRIX_XFER_OVF_EN
    logic                ovf_next;
    logic [ADDR_W:0]     last_addr;
`endif

    assign rd_matrix = buf_q;

    always_comb begin
        state_next = state;
        k_next     = k;
        base_next  = base_q;
        op_next    = op_q;
        buf_next   = buf_q;
        word_next  = '0;
        ld_idx     = 0;
        wr_idx     = 0;
`ifdef MATRIX_XFER_OVF_EN
        ovf_next   = addr_ovf;
        last_addr  = {1'b0, cmd_base} + (ADDR_W+1)'(NUM_WORDS - 1);
`endif

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    base_next  = cmd_base;
                    op_next    = cmd_wr;
                    k_next     = '0;
                    state_next = REQ;
                    if (cmd_wr) begin
                        buf_next = wr_matrix;
                    end
`ifdef MATRIX_XFER_OVF_EN
                    ovf_next = last_addr[ADDR_W];
`endif
                end
            end
            REQ: begin
                if (mem_done) begin
                    state_next = RELEASE;
                    if (!op_q) begin
                        // Bytes beyond the last element (odd final word) are dropped here.
                        for (int unsigned b = 0; b < BPW; b++) begin
                            ld_idx = BPW * k + b;
                            if (ld_idx < NUM_ELEM) begin
                                buf_next[ld_idx*ELEM_W +: ELEM_W] = mem_rdata[b*ELEM_W +: ELEM_W];
                            end
                        end
                    end
                end
            end
            RELEASE: begin
                if (!mem_done) begin
                    if (k == K_LAST) begin
                        state_next = FIN;
                    end else begin
                        k_next     = k + 1'b1;
                        state_next = REQ;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Word about to be presented; padding bytes past the last element stay zero.
        for (int unsigned b = 0; b < BPW; b++) begin
            wr_idx = BPW * k_next + b;
            if (wr_idx < NUM_ELEM) begin
                word_next[b*ELEM_W +: ELEM_W] = buf_next[wr_idx*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            base_q      <= '0;
            op_q        <= 1'b0;
            buf_q       <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            mem_start   <= 1'b0;
            mem_wr      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
`ifdef MATRIX_XFER_OVF_EN
            addr_ovf    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            k         <= k_next;
            base_q    <= base_next;
            op_q      <= op_next;
            buf_q     <= buf_next;
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            xfer_done <= (state_next == FIN);
            mem_start <= (state_next == REQ);
            mem_wr    <= (state_next == REQ) && op_next;
            if (state_next == REQ) begin
                mem_address <= base_next + ADDR_W'(k_next);
                mem_wdata   <= word_next;
            end
`ifdef MATRIX_XFER_OVF_EN
            addr_ovf <= ovf_next;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_xfer.sv
// Scoreboard bench for matrix_xfer: a memory_mod-like model checks every transaction against an expected queue.
// A separate monitor checks each xfer_done pulse and the loaded matrix.
module tb_matrix_xfer;
    import matrix_xfer_pkg::*;

    localparam int MW = N * ELEM_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_wr;
    logic [ADDR_W-1:0]   cmd_base;
    logic [MW-1:0]       wr_matrix;
    logic [MW-1:0]       rd_matrix;
    logic                busy;
    logic                xfer_done;
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_start;
    logic                mem_wr;
    logic                mem_done;
`ifdef MATRIX_XFER_OVF_EN
    logic                addr_ovf;
`endif

    matrix_xfer #(.DIM(DIM), .ELEM_W(ELEM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_base(cmd_base),
        .wr_matrix(wr_matrix), .rd_matrix(rd_matrix), .busy(busy), .xfer_done(xfer_done),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_start(mem_start), .mem_wr(mem_wr), .mem_done(mem_done)
`ifdef MATRIX_XFER_OVF_EN
       ,.addr_ovf(addr_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    typedef struct {
        logic          wr;
        logic [MW-1:0] rd;
    } done_t;

    txn_t  exp_txn[$];
    done_t exp_done[$];
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int failures = 0;
    int lat = 5;
    int hold = 1;
    int done_cnt = 0;
    int txn_cnt = 0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] exp_from_ram(input logic [ADDR_W-1:0] base);
        logic [MW-1:0]     m;
        logic [ADDR_W-1:0] a;
        m = '0;
        for (int i = 0; i < N; i++) begin
            a = base + ADDR_W'(i / 2);
            m[i*ELEM_W +: ELEM_W] = (i % 2 == 0) ? ram[a][7:0] : ram[a][15:8];
        end
        return m;
    endfunction

    // memory_mod-like responder: done after lat cycles, dropped hold cycles after start falls
    initial begin
        int   phase;
        int   cnt;
        txn_t cur;
        phase = 0;
        cnt = 0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
                cnt = 0;
                mem_done = 1'b0;
            end else begin
                case (phase)
                    0: if (mem_start) begin
                        txn_cnt++;
                        if (exp_txn.size() == 0) begin
                            check("unexpected_txn", {1'b1, mem_address}, '0);
                            cur.addr = mem_address;
                            cur.wr = mem_wr;
                            cur.wdata = mem_wdata;
                        end else begin
                            cur = exp_txn.pop_front();
                            check("txn_addr", mem_address, cur.addr);
                            check("txn_wr", mem_wr, cur.wr);
                        end
                        cnt = 1;
                        phase = 1;
                    end
                    1: if (cnt >= lat) begin
                        check("start_held", mem_start, 1);
                        check("addr_held", mem_address, cur.addr);
                        check("wr_held", mem_wr, cur.wr);
                        if (cur.wr) begin
                            check("txn_wdata", mem_wdata, cur.wdata);
                            ram[mem_address] = mem_wdata;
                        end else begin
                            mem_rdata = ram[mem_address];
                        end
                        mem_done = 1'b1;
                        phase = 2;
                    end else begin
                        cnt++;
                    end
                    2: if (!mem_start) begin
                        cnt = 0;
                        phase = 3;
                    end
                    default: begin
                        check("start_low_while_done", mem_start, 0);
                        if (cnt >= hold) begin
                            mem_done = 1'b0;
                            phase = 0;
                        end else begin
                            cnt++;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n && xfer_done) begin
                done_cnt++;
                check("busy_in_fin", busy, 1);
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = exp_done.pop_front();
                    if (!d.wr) check("rd_matrix", rd_matrix, d.rd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] base,
                         input logic [MW-1:0] m, input logic [MW-1:0] exp_rd);
        txn_t  t;
        done_t d;
        int    n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        for (int k = 0; k < W; k++) begin
            t.addr  = base + ADDR_W'(k);
            t.wr    = wr;
            t.wdata = '0;
            if (wr) begin
                t.wdata[7:0]  = m[(2*k)*ELEM_W +: ELEM_W];
                t.wdata[15:8] = (2*k+1 < N) ? m[(2*k+1)*ELEM_W +: ELEM_W] : 8'h00;
            end
            exp_txn.push_back(t);
        end
        d.wr = wr;
        d.rd = exp_rd;
        exp_done.push_back(d);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_base  = base;
        wr_matrix = m;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, busy, 0);
        check({name, "_txn_left"}, exp_txn.size(), 0);
        check({name, "_done_left"}, exp_done.size(), 0);
    endtask

    logic [MW-1:0] m_inc, m_3i, m_wrap;
    int            dc;
    int            tc;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_base = '0;
        wr_matrix = '0;
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = {~8'(a), 8'(a)};
        for (int k = 0; k < W; k++) begin
            ram[8'h10 + k] = {(k < W-1) ? 8'(2*k+2) : 8'h00, 8'(2*k+1)};
            ram[8'(8'hF8 + k)] = {(k < W-1) ? 8'(8'hA0 + 2*k + 1) : 8'hEE, 8'(8'hA0 + 2*k)};
        end
        for (int i = 0; i < N; i++) begin
            m_inc[i*ELEM_W +: ELEM_W]  = 8'(i + 1);
            m_3i[i*ELEM_W +: ELEM_W]   = 8'(3 * i);
            m_wrap[i*ELEM_W +: ELEM_W] = 8'(8'hA0 + i);
        end

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_xfer_done", xfer_done, 0);
        check("rst_mem_start", mem_start, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_matrix", rd_matrix, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 8'h10, '0, m_inc);
        check("busy_after_accept", busy, 1);
        check("ready_low_busy", cmd_ready, 0);
        wait_idle("load");
        check("load_done_count", done_cnt, 1);

        issue(1'b1, 8'h40, m_3i, '0);
        wr_matrix = '1;
        wait_idle("store");
        check("store_word0", ram[8'h40], 16'h0300);
        check("store_word6", ram[8'h46], 16'h2724);
        check("store_word12", ram[8'h4C], 16'h0048);
        check("store_done_count", done_cnt, 2);

        issue(1'b0, 8'hF8, '0, m_wrap);
        wait_idle("wrap");
`ifdef MATRIX_XFER_OVF_EN
        check("ovf_set", addr_ovf, 1);
`endif
        issue(1'b0, 8'h00, '0, exp_from_ram(8'h00));
        wait_idle("load_zero");
`ifdef MATRIX_XFER_OVF_EN
        check("ovf_cleared", addr_ovf, 0);
`endif

        dc = done_cnt;
        issue(1'b0, 8'h10, '0, m_inc);
        repeat (20) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_base  = 8'h80;
        repeat (30) @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("busy_cmd");
        check("busy_cmd_one_done", done_cnt, dc + 1);

        tc = txn_cnt;
        dc = done_cnt;
        issue(1'b0, 8'h10, '0, m_inc);
        for (int n = 0; n < 1000 && txn_cnt < tc + 6; n++) @(negedge clk);
        check("reached_word5", txn_cnt, tc + 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mem_start", mem_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_mem_address", mem_address, 0);
        check("mid_rst_rd_matrix", rd_matrix, 0);
        exp_txn.delete();
        exp_done.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_no_done", done_cnt, dc);
        issue(1'b0, 8'h10, '0, m_inc);
        wait_idle("post_rst_load");

        lat  = 20;
        hold = 3;
        dc = done_cnt;
        issue(1'b0, 8'h40, '0, m_3i);
        wait_idle("slow_load");
        issue(1'b1, 8'h60, m_inc, '0);
        wait_idle("slow_store");
        check("slow_store_word12", ram[8'h6C], 16'h0019);
        check("slow_done_count", done_cnt, dc + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
